// File: rtl/ext_mem_arbiter.sv
// rtl/ext_mem_arbiter.sv - two-requester arbiter for the external memory read/write ports
module ext_mem_arbiter #(
    parameter int ADDR_WIDTH     = 20,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LATENCY   = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                    clk,
    input  logic                    arst_n_in,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [1:0]              req_lock,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    ext_mem_read_en,
    output logic [ADDR_WIDTH-1:0]   ext_mem_read_addr,
    input  logic [DATA_WIDTH-1:0]   ext_mem_qout,
    output logic                    ext_mem_write_en,
    output logic [ADDR_WIDTH-1:0]   ext_mem_write_addr,
    output logic [DATA_WIDTH-1:0]   ext_mem_din
);

    logic                    rd_ptr_q, rd_ptr_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_cand, wr_cand;
    logic                    rd_any, wr_any, rd_id, wr_id, collide, rd_gnt, wr_gnt;
    logic [ADDR_WIDTH-1:0]   addr_a  [2];
    logic [DATA_WIDTH-1:0]   wdata_a [2];
    logic [READ_LATENCY-1:0] pv_q;
    logic [READ_LATENCY-1:0] pid_q;

    always_comb begin
        addr_a[0]  = req_addr[0 +: ADDR_WIDTH];
        addr_a[1]  = req_addr[ADDR_WIDTH +: ADDR_WIDTH];
        wdata_a[0] = req_wdata[0 +: DATA_WIDTH];
        wdata_a[1] = req_wdata[DATA_WIDTH +: DATA_WIDTH];
        rd_cand    = req_valid & ~req_we;
        wr_cand    = req_valid & req_we;
        rd_any     = |rd_cand;
        wr_any     = |wr_cand;
        // With both candidates present the port pointer decides; otherwise the lone candidate wins.
        rd_id      = (rd_cand == 2'b11 && FIXED_PRIORITY == 0) ? rd_ptr_q : !rd_cand[0];
        wr_id      = (wr_cand == 2'b11 && FIXED_PRIORITY == 0) ? wr_ptr_q : !wr_cand[0];
        collide    = rd_any && wr_any && (addr_a[rd_id] == addr_a[wr_id]);
        rd_gnt     = arst_n_in && rd_any && !collide;
        wr_gnt     = arst_n_in && wr_any;

        req_ready[0] = (rd_gnt && !rd_id) || (wr_gnt && !wr_id);
        req_ready[1] = (rd_gnt && rd_id) || (wr_gnt && wr_id);

        ext_mem_read_en    = rd_gnt;
        ext_mem_read_addr  = rd_gnt ? addr_a[rd_id] : '0;
        ext_mem_write_en   = wr_gnt;
        ext_mem_write_addr = wr_gnt ? addr_a[wr_id] : '0;
        ext_mem_din        = wr_gnt ? wdata_a[wr_id] : '0;

        rd_ptr_d = rd_ptr_q;
        if (rd_gnt) rd_ptr_d = req_lock[rd_id] ? rd_id : !rd_id;
        wr_ptr_d = wr_ptr_q;
        if (wr_gnt) wr_ptr_d = req_lock[wr_id] ? wr_id : !wr_id;
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            pv_q     <= '0;
            pid_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            pv_q[0]  <= rd_gnt;
            pid_q[0] <= rd_id;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_q[i]  <= pv_q[i-1];
                pid_q[i] <= pid_q[i-1];
            end
        end
    end

    // The last tag stage lines up with the cycle in which the memory presents the data.
    always_comb begin
        rsp_valid = 2'b00;
        rsp_data  = '0;
        if (pv_q[READ_LATENCY-1]) begin
            rsp_valid = pid_q[READ_LATENCY-1] ? 2'b10 : 2'b01;
            rsp_data  = ext_mem_qout;
        end
    end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb/tb_ext_mem_arbiter.sv - table-driven bench for ext_mem_arbiter
module tb_ext_mem_arbiter;
    localparam int AW = 20;
    localparam int DW = 32;

    typedef struct {
        logic          rst_n;
        logic [1:0]    valid, we, lock;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [1:0]    e_ready;
        logic          e_rd_en;
        logic [AW-1:0] e_rd_addr;
        logic          e_wr_en;
        logic [AW-1:0] e_wr_addr;
        logic [DW-1:0] e_din;
        logic [1:0]    e_rsp_valid;
        logic [DW-1:0] e_rsp_data;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            arst_n;
    logic [1:0]      req_valid, req_we, req_lock;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;

    logic [1:0]    r0_ready, r0_rsp_valid, r1_ready, r1_rsp_valid;
    logic [DW-1:0] r0_rsp_data, r1_rsp_data, qout0, qout1, q1a, r0_din, r1_din;
    logic          r0_rd_en, r0_wr_en, r1_rd_en, r1_wr_en;
    logic [AW-1:0] r0_rd_addr, r0_wr_addr, r1_rd_addr, r1_wr_addr;

    logic [DW-1:0] mem0 [4096];
    logic [DW-1:0] mem1 [4096];

    ext_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .FIXED_PRIORITY(0)) u0 (
        .clk(clk), .arst_n_in(arst_n), .req_valid(req_valid), .req_ready(r0_ready),
        .req_we(req_we), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(r0_rsp_valid), .rsp_data(r0_rsp_data),
        .ext_mem_read_en(r0_rd_en), .ext_mem_read_addr(r0_rd_addr), .ext_mem_qout(qout0),
        .ext_mem_write_en(r0_wr_en), .ext_mem_write_addr(r0_wr_addr), .ext_mem_din(r0_din)
    );

    ext_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .FIXED_PRIORITY(1)) u1 (
        .clk(clk), .arst_n_in(arst_n), .req_valid(req_valid), .req_ready(r1_ready),
        .req_we(req_we), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(r1_rsp_valid), .rsp_data(r1_rsp_data),
        .ext_mem_read_en(r1_rd_en), .ext_mem_read_addr(r1_rd_addr), .ext_mem_qout(qout1),
        .ext_mem_write_en(r1_wr_en), .ext_mem_write_addr(r1_wr_addr), .ext_mem_din(r1_din)
    );

    always @(posedge clk) begin
        if (r0_wr_en) mem0[r0_wr_addr[11:0]] <= r0_din;
        if (r0_rd_en) qout0 <= mem0[r0_rd_addr[11:0]];
        if (r1_wr_en) mem1[r1_wr_addr[11:0]] <= r1_din;
        if (r1_rd_en) q1a <= mem1[r1_rd_addr[11:0]];
        qout1 <= q1a;
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    function automatic vec_t mk(logic rst_n, logic [1:0] valid, logic [1:0] we, logic [1:0] lock,
                                logic [AW-1:0] a0, logic [AW-1:0] a1, logic [DW-1:0] d0, logic [DW-1:0] d1,
                                logic [1:0] e_ready, logic e_rd_en, logic [AW-1:0] e_rd_addr,
                                logic e_wr_en, logic [AW-1:0] e_wr_addr, logic [DW-1:0] e_din,
                                logic [1:0] e_rsp_valid, logic [DW-1:0] e_rsp_data);
        vec_t v;
        v.rst_n = rst_n; v.valid = valid; v.we = we; v.lock = lock;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.e_ready = e_ready; v.e_rd_en = e_rd_en; v.e_rd_addr = e_rd_addr;
        v.e_wr_en = e_wr_en; v.e_wr_addr = e_wr_addr; v.e_din = e_din;
        v.e_rsp_valid = e_rsp_valid; v.e_rsp_data = e_rsp_data;
        return v;
    endfunction

    task automatic drive(logic rst_n, logic [1:0] valid, logic [1:0] we, logic [1:0] lock,
                         logic [AW-1:0] a0, logic [AW-1:0] a1, logic [DW-1:0] d0, logic [DW-1:0] d1);
        arst_n    = rst_n;
        req_valid = valid;
        req_we    = we;
        req_lock  = lock;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle_drive(logic rst_n, logic [1:0] valid, logic [1:0] we,
                               logic [AW-1:0] a0, logic [AW-1:0] a1, logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        drive(rst_n, valid, we, 2'b00, a0, a1, 32'h0, d1);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[12'h010] = 32'hDEADBEEF; mem1[12'h010] = 32'hDEADBEEF;
        mem0[12'h100] = 32'h11110100; mem1[12'h100] = 32'h11110100;
        mem0[12'h200] = 32'h22220200; mem1[12'h200] = 32'h22220200;
        mem0[12'h400] = 32'h44440400; mem1[12'h400] = 32'h44440400;

        // single read, then reset to clear the pointers
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 20'h00010, 0, 0, 0, 2'b01, 1, 20'h00010, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 20'h100, 20'h200, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
        // round-robin reads
        for (int i = 0; i < 6; i++) begin
            logic g1;
            g1 = i[0];
            vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 20'h100, 20'h200, 0, 0,
                              g1 ? 2'b10 : 2'b01, 1, g1 ? 20'h200 : 20'h100, 0, 0, 0,
                              (i == 0) ? 2'b00 : (g1 ? 2'b01 : 2'b10),
                              (i == 0) ? 32'h0 : (g1 ? 32'h11110100 : 32'h22220200)));
        end
        // lock held on requester 0 for five grants, released on the sixth
        for (int i = 0; i < 6; i++) begin
            vecs.push_back(mk(1, 2'b11, 2'b00, (i < 5) ? 2'b01 : 2'b00, 20'h100, 20'h200, 0, 0,
                              2'b01, 1, 20'h100, 0, 0, 0,
                              (i == 0) ? 2'b10 : 2'b01, (i == 0) ? 32'h22220200 : 32'h11110100));
        end
        vecs.push_back(mk(1, 2'b11, 2'b00, 2'b00, 20'h100, 20'h200, 0, 0, 2'b10, 1, 20'h200, 0, 0, 0, 2'b01, 32'h11110100));
        // same-address collision: write wins, read retries and sees new data
        vecs.push_back(mk(1, 2'b11, 2'b01, 2'b00, 20'h300, 20'h300, 32'h5, 0, 2'b01, 0, 0, 1, 20'h300, 32'h5, 2'b10, 32'h22220200));
        vecs.push_back(mk(1, 2'b10, 2'b00, 2'b00, 0, 20'h300, 0, 0, 2'b10, 1, 20'h300, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b10, 32'h5));
        // read and write to different addresses proceed together
        vecs.push_back(mk(1, 2'b11, 2'b10, 2'b00, 20'h400, 20'h500, 0, 32'hA5A5A5A5, 2'b11, 1, 20'h400, 1, 20'h500, 32'hA5A5A5A5, 2'b00, 0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 32'h44440400));

        drive(0, 2'b11, 2'b10, 2'b00, 20'h100, 20'h200, 0, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_gating", {r0_ready, r0_rd_en, r0_wr_en, r1_ready, r1_rd_en, r1_wr_en}, 0);
        check("reset_rsp", {r0_rsp_valid, r1_rsp_valid, r0_rsp_data}, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst_n, vecs[i].valid, vecs[i].we, vecs[i].lock,
                  vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {r0_ready, r0_rd_en, r0_rd_addr, r0_wr_en, r0_wr_addr, r0_din, r0_rsp_valid, r0_rsp_data},
                  {vecs[i].e_ready, vecs[i].e_rd_en, vecs[i].e_rd_addr, vecs[i].e_wr_en,
                   vecs[i].e_wr_addr, vecs[i].e_din, vecs[i].e_rsp_valid, vecs[i].e_rsp_data});
        end

        // reset one cycle after a read on the latency-2 instance drops the response
        cycle_drive(0, 2'b00, 2'b00, 0, 0, 0);
        cycle_drive(1, 2'b01, 2'b00, 20'h10, 0, 0);
        check("rl2_read_issue", {r1_ready, r1_rd_en, r1_rd_addr}, {2'b01, 1'b1, 20'h00010});
        cycle_drive(0, 2'b11, 2'b10, 20'h100, 20'h200, 32'h7);
        check("mid_reset_gating", {r0_ready, r0_rd_en, r0_wr_en, r1_ready, r1_rd_en, r1_wr_en}, 0);
        check("mid_reset_rsp_t1", {r1_rsp_valid}, 2'b00);
        cycle_drive(1, 2'b11, 2'b00, 20'h100, 20'h200, 0);
        check("rsp_dropped_t2", {r1_rsp_valid, r1_rsp_data}, 0);
        check("ptr_after_reset", {r0_ready, r1_ready}, {2'b01, 2'b01});
        cycle_drive(1, 2'b00, 2'b00, 0, 0, 0);
        check("rsp_dropped_t3", {r1_rsp_valid}, 2'b00);
        cycle_drive(1, 2'b00, 2'b00, 0, 0, 0);
        check("rl2_rsp", {r1_rsp_valid, r1_rsp_data}, {2'b01, 32'h11110100});
        cycle_drive(1, 2'b00, 2'b00, 0, 0, 0);
        check("rl2_rsp_single", {r1_rsp_valid, r1_rsp_data}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
